// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared widths and exponent limits for the normalise/round datapath
package fpu_pkg;

  localparam int MANT_W   = 32;
  localparam int EXP_W    = 10;
  localparam int LZC_W    = 5;
  localparam int LZD_W    = 16;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

endpackage

// File: rtl/fpu_lzd_final.sv
// rtl/fpu_lzd_final.sv - LZD layers 3/4: merges four 8-bit group results into the final count
module fpu_lzd_final
  import fpu_pkg::*;
(
  input  logic [LZD_W-1:0] groups,
  output logic             all_zero,
  output logic [LZC_W-1:0] lzc
);

  logic       hi_val, lo_val;
  logic [3:0] hi_pos, lo_pos;

  // Layer 3: each half picks its upper group when that group holds a one.
  always_comb begin
    hi_val = groups[15] | groups[11];
    lo_val = groups[7]  | groups[3];
    hi_pos = groups[15] ? {1'b0, groups[14:12]} : {1'b1, groups[10:8]};
    lo_pos = groups[7]  ? {1'b0, groups[6:4]}   : {1'b1, groups[2:0]};
  end

  // Layer 4
  always_comb begin
    all_zero = ~(hi_val | lo_val);
    lzc      = hi_val ? {1'b0, hi_pos} : {1'b1, lo_pos};
  end

endmodule

// File: rtl/fpu_lzd_normalize.sv
// rtl/fpu_lzd_normalize.sv - two-stage LZD finish, mantissa normalise and exponent adjust
// Flushes zero and underflow to signed zero; saturates the exponent for the rounder.
module fpu_lzd_normalize
  import fpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [MANT_W-1:0]       in_mant,
  input  logic [LZD_W-1:0]        in_lzd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic [7:0]              out_exp,
  output logic [MANT_W-1:0]       out_mant,
  output logic                    out_zero,
  output logic                    out_uf
);

  localparam logic signed [EXP_W:0] EXP_MAX_S = EXP_MAX[EXP_W:0];

  logic                    s2_adv, s1_adv;
  logic                    lzd_zero;
  logic [LZC_W-1:0]        lzd_lzc;

  logic                    s1_valid, s1_sign, s1_zero;
  logic signed [EXP_W-1:0] s1_exp;
  logic [MANT_W-1:0]       s1_mant;
  logic [LZC_W-1:0]        s1_lzc;

  logic [MANT_W-1:0]       shifted;
  logic signed [EXP_W:0]   e_adj;
  logic [7:0]              nxt_exp;
  logic [MANT_W-1:0]       nxt_mant;
  logic                    nxt_zero, nxt_uf;

  fpu_lzd_final u_lzd_final (
    .groups   (in_lzd),
    .all_zero (lzd_zero),
    .lzc      (lzd_lzc)
  );

  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  // One extra exponent bit so subtracting the count never wraps.
  always_comb begin
    shifted  = s1_mant << s1_lzc;
    e_adj    = $signed({s1_exp[EXP_W-1], s1_exp})
             - $signed({{(EXP_W + 1 - LZC_W){1'b0}}, s1_lzc});
    nxt_zero = 1'b0;
    nxt_uf   = 1'b0;
    nxt_exp  = e_adj[7:0];
    nxt_mant = shifted;
    if (s1_zero) begin
      nxt_zero = 1'b1;
      nxt_exp  = '0;
      nxt_mant = '0;
    end else if (e_adj[EXP_W] || (e_adj == '0)) begin
      nxt_zero = 1'b1;
      nxt_uf   = 1'b1;
      nxt_exp  = '0;
      nxt_mant = '0;
    end else if (e_adj >= EXP_MAX_S) begin
      nxt_exp  = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      s1_lzc    <= '0;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_zero  <= 1'b0;
      out_uf    <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (s1_adv) s1_valid  <= in_valid;
        if (s2_adv) out_valid <= s1_valid;
      end
      if (s1_adv && in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_mant <= in_mant;
        s1_lzc  <= lzd_lzc;
        s1_zero <= lzd_zero;
      end
      if (s1_valid && s2_adv) begin
        out_sign <= s1_sign;
        out_exp  <= nxt_exp;
        out_mant <= nxt_mant;
        out_zero <= nxt_zero;
        out_uf   <= nxt_uf;
      end
    end
  end

endmodule

// File: tb/tb_fpu_lzd_normalize.sv
// tb/tb_fpu_lzd_normalize.sv - scoreboard bench for fpu_lzd_normalize
module tb_fpu_lzd_normalize;
  import fpu_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] mant;
    logic        zero;
    logic        uf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_l, flush, in_valid, in_ready, in_sign;
  logic [9:0]  in_exp;
  logic [31:0] in_mant;
  logic [15:0] in_lzd;
  logic        out_valid, out_ready, out_sign, out_zero, out_uf;
  logic [7:0]  out_exp;
  logic [31:0] out_mant;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t q[$];
  res_t held;
  logic held_v = 1'b0;
  logic rand_rdy = 1'b0;

  always #5 clk = ~clk;

  fpu_lzd_normalize dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .in_lzd(in_lzd),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_zero(out_zero), .out_uf(out_uf)
  );

  function automatic res_t ref_model(logic s, logic [9:0] e_in, logic [31:0] m);
    res_t r;
    int   lz, ei, e;
    lz = 0;
    while (lz < 32 && !m[31-lz]) lz++;
    r.sign = s; r.zero = 1'b0; r.uf = 1'b0; r.exp = '0; r.mant = '0;
    if (m == 0) begin
      r.zero = 1'b1;
      return r;
    end
    ei = $signed(e_in);
    e  = ei - lz;
    if (e <= 0) begin
      r.zero = 1'b1;
      r.uf   = 1'b1;
    end else begin
      r.mant = m << lz;
      r.exp  = (e >= 255) ? 8'hFF : 8'(e);
    end
    return r;
  endfunction

  function automatic logic [15:0] make_lzd(logic [31:0] m);
    logic [15:0] g;
    logic [7:0]  sl;
    int          pos;
    g = '0;
    for (int k = 0; k < 4; k++) begin
      sl  = m[8*k +: 8];
      pos = 0;
      while (pos < 8 && !sl[7-pos]) pos++;
      g[4*k +: 4] = {|sl, 3'(pos)};
    end
    return g;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pushes on input handshake, pops on output handshake.
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    cur = {out_sign, out_exp, out_mant, out_zero, out_uf};
    if (!rst_l) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (out_valid && held_v) check("hold_stable", 64'(cur), 64'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %h expected none", cur);
        end else begin
          e = q.pop_front();
          check("result", 64'(cur), 64'(e));
        end
        held_v = 1'b0;
      end else if (out_valid) begin
        held   = cur;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (flush) begin
        q.delete();
        held_v = 1'b0;
      end else if (in_valid && in_ready) begin
        q.push_back(ref_model(in_sign, in_exp, in_mant));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic set_op(logic s, logic [9:0] e, logic [31:0] m);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_lzd = make_lzd(m);
  endtask

  task automatic send(logic s, logic [9:0] e, logic [31:0] m);
    logic acc;
    acc = 1'b0;
    set_op(s, e, m);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_cnt, nv, first, last;
    rst_l = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_mant = '0; in_lzd = '0; out_ready = 1'b1;
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'({out_sign, out_exp, out_mant, out_zero, out_uf}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed cases with latency check on the first
    send(1'b0, 10'd130, 32'h0040_0000);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_s1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_s2", 64'(out_valid), 64'd1);
    check("case1_mant", 64'(out_mant), 64'h8000_0000);
    check("case1_exp", 64'(out_exp), 64'd121);
    drain();
    send(1'b1, 10'd100, 32'h0);
    drain();
    send(1'b0, 10'd20, 32'h0000_0001);
    drain();
    send(1'b0, 10'd300, 32'h0000_0100);
    send(1'b1, 10'd1, 32'h8000_0000);
    send(1'b0, 10'h3F0, 32'h00FF_0000);
    drain();

    // 8 back-to-back ops, results must be on consecutive cycles
    nv = 0; first = -1; last = -1;
    fork
      begin
        for (int k = 0; k < 8; k++) send(k[0], 10'(140 + k), 32'h1 << (4 * k));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          if (out_valid) begin
            nv++;
            if (first < 0) first = c;
            last = c;
          end
        end
      end
    join
    check("b2b_count", 64'(nv), 64'd8);
    check("b2b_span", 64'(last - first + 1), 64'd8);
    drain();

    // Stall: only two ops fit, output held stable
    out_ready = 1'b0;
    acc_cnt = 0;
    set_op(1'b0, 10'd150, 32'h0000_F000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cnt++;
        @(posedge clk); #1;
        set_op(1'b1, 10'(160 + c), 32'h0300_0000 >> c);
      end else begin
        @(posedge clk); #1;
      end
    end
    check("stall_accepts", 64'(acc_cnt), 64'd2);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Flush with two ops in flight and a simultaneous input offer
    out_ready = 1'b0;
    send(1'b0, 10'd200, 32'h0000_0010);
    send(1'b1, 10'd201, 32'h0000_0020);
    set_op(1'b0, 10'd202, 32'h0000_0040);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("flush_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-stream
    send(1'b0, 10'd130, 32'h0001_0000);
    send(1'b1, 10'd131, 32'h0002_0000);
    send(1'b0, 10'd132, 32'h0004_0000);
    in_valid = 1'b0;
    rst_l = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_out_data", 64'({out_sign, out_exp, out_mant, out_zero, out_uf}), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(negedge clk);
    check("rst_release_valid", 64'(out_valid), 64'd0);
    check("rst_release_ready", 64'(in_ready), 64'd1);
    repeat (4) @(negedge clk);
    check("rst_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [9:0]  e;
      logic [31:0] m;
      e = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 290));
      m = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      send(1'($urandom), e, m);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
